// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the timer scheduler and the timer.
// The timer_circle width lives here so both blocks agree on the period width.
// State values are fixed so waveform decoders and the timer side can rely on them.
package timer_pkg;

  // Width of the period bus handed to the timer.
  localparam int TIMER_CIRCLE_W = 8;

  // Scheduler defaults.
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = TIMER_CIRCLE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/period_fifo.sv
// Synchronous period FIFO with host push, scheduler pop and loop re-push at the tail.
// Latency: push visible in count/full/empty on the accepting edge; head is read combinationally.
// Backpressure: rejected writes (zero period, full, or colliding with a re-push) pulse wr_err next cycle.
module period_fifo
  import timer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_period,
  input  logic                       pop,
  input  logic                       loop_mode,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             pop_v;
  logic             repush;
  logic             reject;
  logic             accept;
  logic             push;
  logic [WIDTH-1:0] push_dat;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on an empty queue is meaningless; guard it so occupancy can never underflow.
  assign pop_v  = pop && !empty;
  assign repush = pop_v && loop_mode;

  // Full is judged on the current occupancy, so a same-cycle pop does not make room.
  // A loop re-push owns the tail this cycle, so a host write then has nowhere to go.
  assign reject   = wr_en && ((wr_period == '0) || full || repush);
  assign accept   = wr_en && !reject;
  assign push     = accept || repush;
  assign push_dat = repush ? head : wr_period;

  // Pointers, occupancy and the reject pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= reject;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_v) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop_v) begin
        count <= count + CW'(1);
      end else if (pop_v && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Sequencer that pops queued periods and launches the timer once per entry.
// Latency: write-to-start_flag 2 cycles from idle; timer_over-to-start_flag 1 cycle back-to-back.
// Backpressure: launches wait for timer_over and enable; host writes are rejected via wr_err.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_period,
  input  logic                   enable,
  input  logic                   loop_mode,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   wr_err,
  output logic [WIDTH-1:0]       timer_circle,
  output logic                   start_flag,
  input  logic                   timer_over,
  output logic                   busy,
  output logic                   seq_done
);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic             pop;
  logic             seq_done_nxt;
  logic [WIDTH-1:0] head;

  period_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_period(wr_period),
    .pop      (pop),
    .loop_mode(loop_mode),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .wr_err   (wr_err)
  );

  // LAUNCH lasts exactly one cycle, so start_flag can never repeat on adjacent cycles.
  assign start_flag = (state == LAUNCH);
  assign busy       = (state == LAUNCH) || (state == WAIT);

  // Next-state, pop request and completion pulse decode.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    seq_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        // Dropping enable mid-period never aborts; it only suppresses the next launch.
        if (timer_over) begin
          if (empty) begin
            seq_done_nxt = 1'b1;
            state_nxt    = IDLE;
          end else if (enable) begin
            pop       = 1'b1;
            state_nxt = LAUNCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, launched period and completion pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      timer_circle <= '0;
      seq_done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_done <= seq_done_nxt;
      // Only the pop edge moves timer_circle, keeping it stable through the whole period.
      if (pop) begin
        timer_circle <= head;
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: launch order, rejects, loop mode, enable drop, reset.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
// A negedge monitor counts launches and completion pulses for sequence-level checks.
module tb_timer_scheduler;

  logic       CLK;
  logic       RST;
  logic       wr_en;
  logic [7:0] wr_period;
  logic       enable;
  logic       loop_mode;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       wr_err;
  logic [7:0] timer_circle;
  logic       start_flag;
  logic       timer_over;
  logic       busy;
  logic       seq_done;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int dbl_cnt = 0;
  logic prev_start = 1'b0;
  int snap;

  timer_scheduler #(.DEPTH(4), .WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_en       (wr_en),
    .wr_period   (wr_period),
    .enable      (enable),
    .loop_mode   (loop_mode),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .wr_err      (wr_err),
    .timer_circle(timer_circle),
    .start_flag  (start_flag),
    .timer_over  (timer_over),
    .busy        (busy),
    .seq_done    (seq_done)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor launches, completions and adjacent start_flag cycles.
  always @(negedge CLK) begin
    if (!RST) begin
      if (start_flag) begin
        start_cnt = start_cnt + 1;
        if (prev_start) dbl_cnt = dbl_cnt + 1;
      end
      if (seq_done) done_cnt = done_cnt + 1;
      prev_start = start_flag;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] p);
    wr_en     = 1'b1;
    wr_period = p;
    tick();
    wr_en     = 1'b0;
  endtask

  // Bounded wait for a launch pulse; expiry is reported as a failed comparison.
  task automatic wait_start();
    int i;
    i = 0;
    while (!start_flag && i < 20) begin
      tick();
      i++;
    end
    chk("launch_seen", {31'd0, start_flag}, 32'd1);
  endtask

  initial begin
    RST        = 1'b1;
    wr_en      = 1'b0;
    wr_period  = 8'd0;
    enable     = 1'b0;
    loop_mode  = 1'b0;
    timer_over = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_circle", {24'd0, timer_circle}, 32'd0);
    chk("rst_start", {31'd0, start_flag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    RST = 1'b0;
    tick();

    // Three queued periods run in order, back to back, with one completion pulse.
    push(8'd3);
    push(8'd5);
    push(8'd7);
    chk("q3_count", {29'd0, count}, 32'd3);
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_start();
      chk("seq_circle", {24'd0, timer_circle}, (p == 0) ? 32'd3 : (p == 1) ? 32'd5 : 32'd7);
      tick();
      chk("seq_single_start", {31'd0, start_flag}, 32'd0);
      tick();
      timer_over = 1'b1;
      tick();
      timer_over = 1'b0;
      if (p < 2) begin
        chk("seq_b2b_start", {31'd0, start_flag}, 32'd1);
      end else begin
        chk("seq_done_pulse", {31'd0, seq_done}, 32'd1);
        chk("seq_busy_low", {31'd0, busy}, 32'd0);
      end
    end
    tick();
    chk("seq_done_clear", {31'd0, seq_done}, 32'd0);
    chk("seq_start_total", start_cnt, 32'd3);
    chk("seq_done_total", done_cnt, 32'd1);

    // Zero period is rejected and never launches.
    snap = start_cnt;
    push(8'd0);
    chk("zero_wr_err", {31'd0, wr_err}, 32'd1);
    chk("zero_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("zero_wr_err_clear", {31'd0, wr_err}, 32'd0);
    tick();
    chk("zero_no_start", start_cnt, snap);

    // Loop mode rotates 2,4 with constant occupancy; a colliding write is rejected.
    enable = 1'b0;
    push(8'd2);
    push(8'd4);
    loop_mode = 1'b1;
    enable    = 1'b1;
    snap      = done_cnt;
    for (int p = 0; p < 6; p++) begin
      wait_start();
      chk("loop_circle", {24'd0, timer_circle}, (p % 2 == 1) ? 32'd4 : 32'd2);
      chk("loop_count", {29'd0, count}, 32'd2);
      tick();
      tick();
      timer_over = 1'b1;
      if (p == 0) begin
        wr_en     = 1'b1;
        wr_period = 8'd9;
      end
      tick();
      timer_over = 1'b0;
      wr_en      = 1'b0;
      if (p == 0) begin
        chk("loop_collide_wr_err", {31'd0, wr_err}, 32'd1);
        chk("loop_collide_count", {29'd0, count}, 32'd2);
      end
    end
    chk("loop_no_done", done_cnt, snap);

    // Enable dropped during the period: finish it, return to IDLE quietly, resume on enable.
    loop_mode = 1'b0;
    enable    = 1'b0;
    tick();
    chk("drop_busy_wait", {31'd0, busy}, 32'd1);
    tick();
    timer_over = 1'b1;
    tick();
    timer_over = 1'b0;
    chk("drop_idle", {31'd0, busy}, 32'd0);
    chk("drop_no_start", {31'd0, start_flag}, 32'd0);
    chk("drop_no_done", {31'd0, seq_done}, 32'd0);
    chk("drop_count", {29'd0, count}, 32'd2);
    tick();
    chk("drop_still_idle", {31'd0, start_flag}, 32'd0);
    enable = 1'b1;
    tick();
    chk("resume_start", {31'd0, start_flag}, 32'd1);
    chk("resume_circle", {24'd0, timer_circle}, 32'd4);
    chk("resume_count", {29'd0, count}, 32'd1);
    chk("resume_done_total", done_cnt, snap);

    // Clean slate, then fill to capacity and overflow.
    RST = 1'b1;
    tick();
    RST    = 1'b0;
    enable = 1'b0;
    push(8'd1);
    push(8'd2);
    push(8'd3);
    push(8'd4);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_full", {31'd0, full}, 32'd1);
    push(8'd5);
    chk("ovf_wr_err", {31'd0, wr_err}, 32'd1);
    chk("ovf_count", {29'd0, count}, 32'd4);
    chk("ovf_full", {31'd0, full}, 32'd1);

    // Write while full is rejected even though the same edge pops.
    enable    = 1'b1;
    wr_en     = 1'b1;
    wr_period = 8'd6;
    tick();
    chk("fullpop_wr_err", {31'd0, wr_err}, 32'd1);
    chk("fullpop_count", {29'd0, count}, 32'd3);
    chk("fullpop_start", {31'd0, start_flag}, 32'd1);
    chk("fullpop_circle", {24'd0, timer_circle}, 32'd1);
    tick();
    wr_en = 1'b0;
    chk("refill_count", {29'd0, count}, 32'd4);
    chk("refill_wr_err", {31'd0, wr_err}, 32'd0);
    chk("refill_busy", {31'd0, busy}, 32'd1);
    tick();

    // Asynchronous reset in WAIT with a full queue.
    RST = 1'b1;
    #1;
    chk("arst_circle", {24'd0, timer_circle}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_start", {31'd0, start_flag}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    tick();
    RST  = 1'b0;
    snap = start_cnt;
    for (int i = 0; i < 5; i++) tick();
    chk("arst_no_start", start_cnt, snap);

    // First launch latency after a fresh write.
    push(8'd3);
    chk("first_count", {29'd0, count}, 32'd1);
    chk("first_not_yet", {31'd0, start_flag}, 32'd0);
    tick();
    chk("first_start", {31'd0, start_flag}, 32'd1);
    chk("first_circle", {24'd0, timer_circle}, 32'd3);
    tick();

    chk("no_adjacent_starts", dbl_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
